// File: rtl/mic1_uart_tx.sv
// MIC-1 SoC transmit UART: 8N1, LSB first, fed through a small power-of-2 write FIFO.
// Handshake: a byte moves on a rising edge where wr_valid && wr_ready; wr_ready depends only on registered state.
module mic1_uart_tx #(
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [1:0]                    state_dbg
);

    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);
    localparam logic [AW:0] FULL   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [15:0]   baud_cnt, baud_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_q, tx_n;
    logic          pop, push, bit_end, fifo_nonempty;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    assign push          = wr_valid && wr_ready;
    assign bit_end       = (baud_cnt == 16'd0);
    assign fifo_nonempty = (count != '0);

    assign wr_ready   = (count != FULL);
    assign busy       = (state != S_IDLE) || fifo_nonempty;
    assign fifo_count = count;
    assign tx         = tx_q;
    assign state_dbg  = state;

    // tx_n is the line level for the cycle after the edge, so tx stays a plain flop.
    always_comb begin
        state_n    = state;
        baud_cnt_n = bit_end ? RELOAD : baud_cnt - 16'd1;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        tx_n       = tx_q;
        pop        = 1'b0;
        unique case (state)
            S_IDLE: begin
                tx_n       = 1'b1;
                baud_cnt_n = 16'd0;
                if (fifo_nonempty) begin
                    pop        = 1'b1;
                    shreg_n    = mem[rd_ptr];
                    baud_cnt_n = RELOAD;
                    state_n    = S_START;
                    tx_n       = 1'b0;
                end
            end
            S_START: begin
                tx_n = 1'b0;
                if (bit_end) begin
                    state_n   = S_DATA;
                    bit_idx_n = 3'd0;
                    tx_n      = shreg[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shreg[1];
                    end
                end
            end
            S_STOP: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shreg_n = mem[rd_ptr];
                        state_n = S_START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n    = S_IDLE;
                        baud_cnt_n = 16'd0;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            tx_q     <= tx_n;
        end
    end

    // Pointers wrap for free because the depth is a power of 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: tb/tb_mic1_uart_tx.sv
// Bench for mic1_uart_tx: two instances (CLK_DIV 4 and 2) checked every cycle against a
// frame-schedule model (start = max(accept+1, previous frame end), 10 bit-times per frame).
module tb_mic1_uart_tx;

    localparam int DEPTH = 4;
    localparam int MAXF  = 512;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       wr_valid_s [2];
    logic [7:0] wr_data_s  [2];
    logic       ready_s    [2];
    logic       tx_s       [2];
    logic       busy_s     [2];
    logic [2:0] cnt_s      [2];
    logic [1:0] dbg_s      [2];

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    bit         req_valid [2];
    logic [7:0] req_data  [2];
    bit         last_acc  [2];

    int         divs      [2];
    int         fr_acc    [2][MAXF];
    int         fr_start  [2][MAXF];
    logic [7:0] fr_byte   [2][MAXF];
    int         n_fr      [2];
    int         last_end  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mic1_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid_s[0]), .wr_data(wr_data_s[0]),
        .wr_ready(ready_s[0]), .tx(tx_s[0]), .busy(busy_s[0]), .fifo_count(cnt_s[0]),
        .state_dbg(dbg_s[0])
    );

    mic1_uart_tx #(.CLK_DIV(2), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid_s[1]), .wr_data(wr_data_s[1]),
        .wr_ready(ready_s[1]), .tx(tx_s[1]), .busy(busy_s[1]), .fifo_count(cnt_s[1]),
        .state_dbg(dbg_s[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---- reference model: levels derived from the frame schedule ----
    function automatic logic m_tx(input int i, input int n);
        for (int k = 0; k < n_fr[i]; k++) begin
            int off;
            off = n - fr_start[i][k];
            if (off >= 0 && off < 10 * divs[i]) begin
                int b;
                b = off / divs[i];
                if (b == 0) return 1'b0;
                if (b == 9) return 1'b1;
                return fr_byte[i][k][b-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic int m_count(input int i, input int n);
        int c;
        c = 0;
        for (int k = 0; k < n_fr[i]; k++)
            if (fr_acc[i][k] <= n && fr_start[i][k] > n) c++;
        return c;
    endfunction

    function automatic logic m_busy(input int i, input int n);
        if (m_count(i, n) != 0) return 1'b1;
        for (int k = 0; k < n_fr[i]; k++)
            if (n >= fr_start[i][k] && n < fr_start[i][k] + 10 * divs[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_frame(input int i, input int edge_n, input logic [7:0] b);
        int s;
        s = (edge_n + 1 > last_end[i]) ? edge_n + 1 : last_end[i];
        if (n_fr[i] < MAXF) begin
            fr_acc[i][n_fr[i]]   = edge_n;
            fr_start[i][n_fr[i]] = s;
            fr_byte[i][n_fr[i]]  = b;
            n_fr[i]++;
        end
        last_end[i] = s + 10 * divs[i];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            n_fr[i]     = 0;
            last_end[i] = 0;
        end
    endtask

    // One cycle: compare outputs at the falling edge, then drive the next edge's inputs.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("tx%0d", i),    32'(tx_s[i]),    32'(m_tx(i, cyc)));
            check_eq($sformatf("count%0d", i), 32'(cnt_s[i]),   32'(m_count(i, cyc)));
            check_eq($sformatf("busy%0d", i),  32'(busy_s[i]),  32'(m_busy(i, cyc)));
            check_eq($sformatf("ready%0d", i), 32'(ready_s[i]), 32'(m_count(i, cyc) != DEPTH));
        end
        for (int i = 0; i < 2; i++) begin
            last_acc[i]   = req_valid[i] && !reset && (m_count(i, cyc) != DEPTH);
            wr_valid_s[i] = req_valid[i];
            wr_data_s[i]  = req_data[i];
            if (last_acc[i]) add_frame(i, cyc + 1, req_data[i]);
        end
    endtask

    task automatic wait_to(input int n);
        int g;
        g = 0;
        while (cyc < n && g < 5000) begin
            tick();
            g++;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((cyc < last_end[0] || cyc < last_end[1]) && g < 3000) begin
            tick();
            g++;
        end
        repeat (3) tick();
    endtask

    task automatic push(input int i, input logic [7:0] b);
        req_valid[i] = 1'b1;
        req_data[i]  = b;
        tick();
        req_valid[i] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        int e1, nxt, acc_n, s, bc;
        bit seen, rec;
        logic [7:0] b3 [3];
        divs[0] = 4;
        divs[1] = 2;
        model_clear();
        for (int i = 0; i < 2; i++) begin
            req_valid[i]  = 1'b0;
            req_data[i]   = 8'h00;
            wr_valid_s[i] = 1'b0;
            wr_data_s[i]  = 8'h00;
            last_acc[i]   = 1'b0;
        end

        // Reset with no clock edges yet
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_tx",    32'(tx_s[i]),    32'd1);
            check_eq("rst_ready", 32'(ready_s[i]), 32'd1);
            check_eq("rst_busy",  32'(busy_s[i]),  32'd0);
            check_eq("rst_count", 32'(cnt_s[i]),   32'd0);
        end
        repeat (3) tick();
        #1 reset = 1'b0;

        // Single byte 0x55
        push(0, 8'h55);
        e1 = fr_acc[0][n_fr[0]-1] + 1;
        wait_to(e1);
        check_eq("single_cnt_e1", 32'(cnt_s[0]), 32'd0);
        check_eq("single_tx_e1",  32'(tx_s[0]),  32'd0);
        wait_to(e1 + 39);
        check_eq("single_busy_39", 32'(busy_s[0]), 32'd1);
        wait_to(e1 + 40);
        check_eq("single_busy_40", 32'(busy_s[0]), 32'd0);
        drain();

        // Fill and backpressure with 0x01..0x07 held valid
        nxt = 1; acc_n = 0; seen = 0; rec = 0;
        for (int g = 0; g < 600 && nxt <= 7; g++) begin
            req_valid[0] = 1'b1;
            req_data[0]  = 8'(nxt);
            tick();
            if (!seen && !ready_s[0]) begin
                seen = 1;
                check_eq("fill_accepts", 32'(acc_n),    32'd5);
                check_eq("fill_count",   32'(cnt_s[0]), 32'd4);
            end else if (seen && !rec && ready_s[0]) begin
                rec = 1;
                check_eq("ready_recover_cnt", 32'(cnt_s[0]), 32'd3);
            end
            if (last_acc[0]) begin
                nxt++;
                acc_n++;
            end
        end
        req_valid[0] = 1'b0;
        check_eq("fill_saw_full",   32'(seen), 32'd1);
        check_eq("fill_saw_recover", 32'(rec), 32'd1);
        drain();

        // Push on the same edge as a STOP-end pop with two bytes queued
        b3[0] = 8'h3C; b3[1] = 8'hC3; b3[2] = 8'h99;
        for (int k = 0; k < 3; k++) begin
            req_valid[0] = 1'b1;
            req_data[0]  = b3[k];
            tick();
        end
        req_valid[0] = 1'b0;
        s = fr_start[0][n_fr[0]-3] + 40;
        wait_to(s - 2);
        check_eq("pushpop_pre_cnt", 32'(cnt_s[0]), 32'd2);
        push(0, 8'h5A);
        tick();
        check_eq("pushpop_cnt", 32'(cnt_s[0]), 32'd2);
        drain();

        // Reset during data bit 3 of 0xA3 with two bytes queued
        b3[0] = 8'hA3; b3[1] = 8'h11; b3[2] = 8'h22;
        for (int k = 0; k < 3; k++) begin
            req_valid[0] = 1'b1;
            req_data[0]  = b3[k];
            tick();
        end
        req_valid[0] = 1'b0;
        s = fr_start[0][n_fr[0]-3];
        wait_to(s + 17);
        check_eq("mid_pre_tx",  32'(tx_s[0]),  32'd0);
        check_eq("mid_pre_cnt", 32'(cnt_s[0]), 32'd2);
        #2 reset = 1'b1;
        model_clear();
        #1;
        check_eq("mid_rst_tx",    32'(tx_s[0]),    32'd1);
        check_eq("mid_rst_cnt",   32'(cnt_s[0]),   32'd0);
        check_eq("mid_rst_busy",  32'(busy_s[0]),  32'd0);
        check_eq("mid_rst_ready", 32'(ready_s[0]), 32'd1);
        tick();
        #1 reset = 1'b0;
        repeat (60) tick();
        push(0, 8'h0F);
        drain();

        // Randomized traffic on both instances
        for (int r = 0; r < 400; r++) begin
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = ($urandom_range(0, 3) == 0);
                req_data[i]  = 8'($urandom_range(0, 255));
            end
            tick();
        end
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        drain();

        // CLK_DIV=2: 0xFF then 0x00, one queued cycle plus two 20-cycle frames of busy
        bc = 0;
        req_valid[1] = 1'b1;
        req_data[1]  = 8'hFF;
        tick();
        req_data[1]  = 8'h00;
        tick();
        if (busy_s[1]) bc++;
        req_valid[1] = 1'b0;
        repeat (60) begin
            tick();
            if (busy_s[1]) bc++;
        end
        check_eq("div2_busy_cycles", 32'(bc), 32'd41);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
